multdiv_sequencer: RTL

- Controls the shared iterative multdiv unit in the execute stage of the 5-stage pipeline.
- Detects a mul/div instruction in X and issues a one-cycle start pulse to multdiv.
- Holds the stall to the F, F/D and D/X latches until multdiv reports a result, or until a watchdog expires.
- Presents the registered result, exception flag and rstatus code for one cycle so the X/M latch captures them.

---
 rtl/multdiv_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - start/stall/result sequencer for the shared iterative multdiv unit
//
// Watches the instruction in X. On a mul/div it pulses the multdiv start line for one cycle,
// stalls the front of the pipeline, and then presents the registered result for one cycle.
//
// Ports:
//   clock, reset           rising-edge clock; asynchronous active-high reset
//   x_insn, x_kill         instruction in D/X and its flush flag
//   ctrl_MULT, ctrl_DIV    one-cycle start pulses to multdiv
//   md_result, md_exception, md_ready
//                          multdiv result, exception flag and result-ready
//   stall                  freezes PC, F/D and D/X and inserts a nop into X/M
//   res_valid              one-cycle strobe; X/M selects res_data while it is high
//   res_data, res_exc, rstatus_code
//                          registered result, exception flag and status code (4 mul, 5 div)
module multdiv_sequencer #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] x_insn,
    input  logic        x_kill,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        stall,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_exc,
    output logic [31:0] rstatus_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_div_q, op_div_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             res_exc_q, res_exc_d;
    logic [2:0]       code_q, code_d;

    logic is_mul, is_div, md_req;
    logic mult_c, div_c, stall_c, valid_c;

    // Only opcode and aluop take part in the decode; the register fields are don't-care.
    logic unused_insn_bits;
    assign unused_insn_bits = ^{x_insn[26:7], x_insn[1:0]};

    assign is_mul = (x_insn[31:27] == 5'b00000) && (x_insn[6:2] == 5'b00110);
    assign is_div = (x_insn[31:27] == 5'b00000) && (x_insn[6:2] == 5'b00111);
    assign md_req = (is_mul || is_div) && !x_kill;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_div_d   = op_div_q;
        res_data_d = res_data_q;
        res_exc_d  = res_exc_q;
        code_d     = code_q;
        mult_c     = 1'b0;
        div_c      = 1'b0;
        stall_c    = 1'b0;
        valid_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (md_req) begin
                    mult_c   = is_mul;
                    div_c    = is_div;
                    stall_c  = 1'b1;
                    op_div_d = is_div;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (x_kill) begin
                    // Flushed instruction: drop the operation, keep the previous result.
                    state_d = S_IDLE;
                end else if (md_ready) begin
                    state_d    = S_DONE;
                    res_exc_d  = md_exception;
                    res_data_d = md_exception ? 32'd0 : md_result;
                    code_d     = md_exception ? (op_div_q ? 3'd5 : 3'd4) : 3'd0;
                end else if (cnt_q == CNT_LAST) begin
                    // Watchdog: multdiv never answered, report it as an exception.
                    state_d    = S_DONE;
                    res_exc_d  = 1'b1;
                    res_data_d = 32'd0;
                    code_d     = op_div_q ? 3'd5 : 3'd4;
                end
            end
            S_DONE: begin
                // X still holds the finished instruction here, so md_req is ignored.
                valid_c = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_div_q   <= 1'b0;
            res_data_q <= 32'd0;
            res_exc_q  <= 1'b0;
            code_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_div_q   <= op_div_d;
            res_data_q <= res_data_d;
            res_exc_q  <= res_exc_d;
            code_q     <= code_d;
        end
    end

    // The IDLE-state pulses are combinational on x_insn; masking them with reset keeps
    // every output low for the whole time reset is held, even with a mul/div sitting in X.
    assign ctrl_MULT    = mult_c && !reset;
    assign ctrl_DIV     = div_c && !reset;
    assign stall        = stall_c && !reset;
    assign res_valid    = valid_c;
    assign res_data     = res_data_q;
    assign res_exc      = res_exc_q;
    assign rstatus_code = {29'd0, code_q};

endmodule
